shift_rows_stream: RTL
======================

Name: shift_rows_stream

Overview:
- Parametrised, pipelined ShiftRows / InvShiftRows stage for the AES/Rijndael datapath, with a valid/ready stream interface.
- Supports Rijndael block widths of Nb = 4, 6 or 8 columns.
- Direction is selected per transfer by a mode bit, so one instance serves both the encrypt and decrypt round pipelines.
- An optional skid buffer registers in_ready to break long ready paths between round stages.

Parameters:
- NB, 4, number of state columns; legal values 4, 6, 8. Any other value is an elaboration error.
- REG_READY, 0, selects the ready path. 0: combinational in_ready. 1: in_ready is registered, backed by a 1-entry skid buffer.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_inv  in  1  per-beat mode; 0 = ShiftRows, 1 = InvShiftRows.
- in_data  in  32*NB  input state.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  32*NB  shifted state.

Behaviour:
- Byte mapping:
  - Byte k occupies bits [32*NB-1-8k -: 8], so byte 0 is the MSB byte.
  - State is column-major: row r = k mod 4, column c = k div 4.
- Row offsets s_r:
  - NB = 4 or 6: s = {0,1,2,3}.
  - NB = 8: s = {0,1,3,4}.
- Transform, with column indices taken mod NB:
  - Forward: out[r][c] = in[r][c+s_r].
  - Inverse: out[r][c] = in[r][c-s_r].
  - The transform is purely byte permutation, with no arithmetic.
- Transfers:
  - An input transfer occurs on a rising edge where in_valid && in_ready.
  - An output transfer occurs on a rising edge where out_valid && out_ready.
  - in_inv is sampled with in_data at the input transfer and applies to that beat only.
- Latency: 1 cycle. A beat accepted at edge N is presented on out_data with out_valid=1 after edge N.
- Throughput: 1 beat/cycle when out_ready is held high, for both REG_READY values.
- REG_READY=0:
  - in_ready = !out_valid || out_ready (combinational).
  - Simultaneous input and output transfers replace the output register in the same edge, so there are no bubbles.
- REG_READY=1:
  - in_ready is a flop equal to "skid empty".
  - If an input transfers while out_valid=1 && out_ready=0, the transformed beat goes to the skid register and in_ready drops on the next cycle.
  - On the next output transfer, skid contents move to the output register and the skid empties.
  - The skid never overwrites valid data, and beat order is preserved.
- Output stability: while out_valid=1 && out_ready=0, out_data must not change.
- Reset (rst_n=0 at an edge):
  - out_valid=0, out_data=0, skid emptied.
  - in_ready=0 while rst_n is sampled low; in_ready=1 from the first cycle after rst_n is sampled high.
  - Reset mid-stream discards all held beats; no partial beat survives.
  - in_valid is ignored while in reset.
- No X propagation: out_data holds its last value (or 0 after reset) when out_valid=0.

Test Plan:
- Forward, NB=4:
  - Stimulus: in_inv=0, in_data=000102030405060708090a0b0c0d0e0f, out_ready=1.
  - Required: out_data=00050a0f04090e03080d02070c01060b with out_valid=1 exactly 1 cycle later.
- Inverse, NB=4:
  - Stimulus: in_inv=1, in_data=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out_data=69b4b7306ac4c580d87be05a70cd04d8.
  - Feed that result back with in_inv=0; required: original input is restored.
- Forward, NB=8:
  - Stimulus: in_data=bytes 00..1f ascending.
  - Required: out_data top word 00050e13, bottom word 1c010a0f.
  - Run the inverse of that result; required: ascending bytes are returned.
- Back-pressure, both REG_READY values:
  - Stimulus: 8 back-to-back beats with alternating in_inv, while out_ready toggles pseudo-randomly.
  - Required: all 8 outputs arrive in order, each with its own mode.
  - Required: out_data stays stable while stalled; no beat is lost or duplicated.
  - Required: with out_ready held at 1, one beat arrives per cycle.
- Skid fill (REG_READY=1):
  - Stimulus: out_ready=0, in_valid=1 continuously.
  - Required: exactly 2 beats are accepted, and in_ready=0 from the cycle after the second acceptance.
  - Then raise out_ready; required: both beats drain in order and in_ready returns to 1.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 for 1 cycle with the output and skid both holding beats.
  - Required: next cycle out_valid=0 and out_data=0.
  - Required: in_ready=1 one cycle after rst_n is sampled high.
  - Required: stale beats never appear on the output.

Source files
------------

// File: rtl/shift_rows_stream.sv
// AES/Rijndael ShiftRows / InvShiftRows stage with a valid/ready stream
// interface and one cycle of latency. Supports NB = 4, 6 or 8 columns.
// The direction is chosen per beat by in_inv.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_inv              per-beat mode: 0 = ShiftRows, 1 = InvShiftRows
//   in_data             input state, byte 0 in the MSB byte, column-major
//   out_valid/out_ready output handshake
//   out_data            shifted state, held stable while stalled
//
// Parameter REG_READY = 1 registers in_ready and adds a one-entry skid buffer.
module shift_rows_stream #(
  parameter int unsigned NB        = 4,
  parameter int unsigned REG_READY = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_inv,
  input  logic [32*NB-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*NB-1:0] out_data
);

  localparam int unsigned W      = 32 * NB;
  localparam int unsigned NBYTES = 4 * NB;

  // Reject unsupported block widths at elaboration.
  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_stream: NB must be 4, 6 or 8");
  end

  // Row offsets: {0,1,2,3} for NB = 4/6, {0,1,3,4} for NB = 8.
  function automatic int unsigned row_shift(input int unsigned r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  logic [W-1:0] fwd_perm;
  logic [W-1:0] inv_perm;
  logic [W-1:0] xformed;

  // Pure byte permutation; source byte indices fold to constants.
  for (genvar k = 0; k < NBYTES; k++) begin : g_byte
    localparam int unsigned KU = k;
    localparam int unsigned R  = KU % 4;
    localparam int unsigned C  = KU / 4;
    localparam int unsigned S  = row_shift(R);
    localparam int unsigned SF = R + 4 * ((C + S) % NB);
    localparam int unsigned SI = R + 4 * ((C + NB - S) % NB);
    assign fwd_perm[W-1-8*KU -: 8] = in_data[W-1-8*SF -: 8];
    assign inv_perm[W-1-8*KU -: 8] = in_data[W-1-8*SI -: 8];
  end

  assign xformed = in_inv ? inv_perm : fwd_perm;

  logic         ready_q;
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         out_valid_n;
  logic [W-1:0] out_data_n;
  logic         skid_valid_n;
  logic [W-1:0] skid_data_n;
  logic         accept;
  logic         drain;

  // ready_q is low for the cycle after a reset edge in both modes.
  assign in_ready = (REG_READY != 0) ? ready_q
                                     : (ready_q && (!out_valid || out_ready));
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  // Next-state for the output register and the skid entry.
  always_comb begin
    out_valid_n  = out_valid;
    out_data_n   = out_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (REG_READY == 0) begin
      if (accept) begin
        out_valid_n = 1'b1;
        out_data_n  = xformed;
      end else if (drain) begin
        out_valid_n = 1'b0;
      end
    end else begin
      if (drain) begin
        // Skid full implies in_ready low, so accept cannot coincide here.
        if (skid_valid) begin
          out_data_n   = skid_data;
          skid_valid_n = 1'b0;
        end else if (accept) begin
          out_data_n = xformed;
        end else begin
          out_valid_n = 1'b0;
        end
      end else if (accept) begin
        if (!out_valid) begin
          out_valid_n = 1'b1;
          out_data_n  = xformed;
        end else begin
          skid_valid_n = 1'b1;
          skid_data_n  = xformed;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      ready_q    <= 1'b0;
    end else begin
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      ready_q    <= (REG_READY != 0) ? !skid_valid_n : 1'b1;
    end
  end

endmodule
